// File: rtl/sram_256x16.sv
// 256 x 16 single-port synchronous SRAM with a shared tri-state data bus and active-low controls.
// Optional macro SRAM_MEM_CLEAR_EN: reset also clears every memory word in the same cycle.

module sram_256x16_chk #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input logic                  clk,
  input logic                  reset,
  input logic [ADDR_WIDTH-1:0] address,
  input logic [DATA_WIDTH-1:0] data,
  input logic                  chip_enable,
  input logic                  write_enable
);

  // A write with an unknown address or data word leaves the target location undefined.
  always @(posedge clk) begin
    if (reset === 1'b1 && chip_enable === 1'b0 && write_enable === 1'b0) begin
      x_write_a: assert (!$isunknown({address, data}))
        else $warning("sram_256x16: write with X/Z address or data at %0t", $time);
    end
  end

endmodule

module sram_256x16 #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  chip_enable,
  input  logic                  write_enable,
  input  logic                  output_enable
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_q_r;
  logic                  wr_s;
  logic                  rd_s;
  logic                  drive_s;

  // Decode the active-low strobes into write/read/bus-drive qualifiers.
  always_comb begin
    wr_s    = (reset == 1'b1) && (chip_enable == 1'b0) && (write_enable == 1'b0);
    rd_s    = (reset == 1'b1) && (chip_enable == 1'b0) && (write_enable == 1'b1);
    drive_s = rd_s && (output_enable == 1'b0);
  end

  // Memory array: reset wins over a coincident write strobe.
  always_ff @(posedge clk) begin
    if (reset == 1'b0) begin
`ifdef SRAM_MEM_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i[ADDR_WIDTH-1:0]] <= {DATA_WIDTH{1'b0}};
      end
`endif
    end else if (wr_s) begin
      mem_r[address] <= data;
    end
  end

  // Read register: loads on every read edge, even when the bus is not enabled.
  always_ff @(posedge clk) begin
    if (reset == 1'b0) begin
      rd_q_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_s) begin
      rd_q_r <= mem_r[address];
    end
  end

  assign data = drive_s ? rd_q_r : {DATA_WIDTH{1'bz}};

`ifndef SYNTHESIS
  sram_256x16_chk #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_chk (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .data         (data),
    .chip_enable  (chip_enable),
    .write_enable (write_enable)
  );
`endif

endmodule

// File: tb/tb_sram_256x16.sv
// Self-checking bench for sram_256x16: vector table plus hand-written corner sequences.
// When the DUT must not drive, the bench drives a known value and expects to read it back unchanged.
module tb_sram_256x16;

  logic        clk;
  logic        reset;
  logic [7:0]  address;
  logic        chip_enable;
  logic        write_enable;
  logic        output_enable;
  logic        tb_drv;
  logic [15:0] tb_val;
  wire  [15:0] data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] val;
    bit          chk;
    string       name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    string       name;
    logic        rst;
    logic        ce;
    logic        we;
    logic        oe;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[12];

  assign data = tb_drv ? tb_val : 16'hzzzz;

  sram_256x16 dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .data          (data),
    .chip_enable   (chip_enable),
    .write_enable  (write_enable),
    .output_enable (output_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input string nm, input logic r, input logic ce, input logic we,
                       input logic oe, input logic [7:0] a, input logic [15:0] wd,
                       input logic [15:0] ex, input bit ck);
    sb_t e;
    reset = r; chip_enable = ce; write_enable = we; output_enable = oe; address = a;
    if (r && !ce && we && !oe) begin
      tb_drv = 1'b0;
      e.val  = ex;
      e.chk  = ck;
    end else begin
      tb_drv = 1'b1;
      tb_val = we ? 16'h0000 : wd;
      e.val  = tb_val;
      e.chk  = 1'b1;
    end
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    if (e.chk) begin
      checks++;
      if (data !== e.val) begin
        errors++;
        $display("FAIL %s: data=%h expected=%h at %0t", e.name, data, e.val, $time);
      end
    end
  endtask

  initial begin
    logic [15:0] exp_clr;
    bit          chk_clr;
`ifdef SRAM_MEM_CLEAR_EN
    chk_clr = 1'b1;
`else
    chk_clr = 1'b0;
`endif

    tbl[0]  = '{"wr_12",   1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 16'hABCD, 16'h0000};
    tbl[1]  = '{"rd_12",   1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 16'h0000, 16'hABCD};
    tbl[2]  = '{"wr_fe",   1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 16'h0001, 16'h0000};
    tbl[3]  = '{"wr_ff",   1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 16'h0002, 16'h0000};
    tbl[4]  = '{"wr_00",   1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0003, 16'h0000};
    tbl[5]  = '{"wr_01",   1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 16'h0004, 16'h0000};
    tbl[6]  = '{"burst_fe",1'b1, 1'b0, 1'b1, 1'b0, 8'hFE, 16'h0000, 16'h0001};
    tbl[7]  = '{"burst_ff",1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000, 16'h0002};
    tbl[8]  = '{"burst_00",1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0003};
    tbl[9]  = '{"burst_01",1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 16'h0000, 16'h0004};
    tbl[10] = '{"wr_40",   1'b1, 1'b0, 1'b0, 1'b1, 8'h40, 16'h5A5A, 16'h0000};
    tbl[11] = '{"rd_40",   1'b1, 1'b0, 1'b1, 1'b0, 8'h40, 16'h0000, 16'h5A5A};

    tb_drv = 1'b0; tb_val = 16'h0000;
    reset = 1'b0; chip_enable = 1'b0; write_enable = 1'b1; output_enable = 1'b0; address = 8'h00;

    // Reset held two cycles with a read set up: bus must stay released.
    apply("rst_z0", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1);
    apply("rst_z1", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1);
    apply("rst_rd00", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, chk_clr);

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].name, tbl[i].rst, tbl[i].ce, tbl[i].we, tbl[i].oe,
            tbl[i].addr, tbl[i].wdata, tbl[i].exp, 1'b1);
    end

    // Bus control: oe high, then chip deselected, then a write with oe low.
    apply("oe_hi_z",  1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 16'h0000, 16'h0000, 1'b1);
    apply("ce_hi_z",  1'b1, 1'b1, 1'b1, 1'b0, 8'h40, 16'h0000, 16'h0000, 1'b1);
    apply("wr_no_cont", 1'b1, 1'b0, 1'b0, 1'b0, 8'h41, 16'h7777, 16'h0000, 1'b1);
    apply("rd_41",    1'b1, 1'b0, 1'b1, 1'b0, 8'h41, 16'h0000, 16'h7777, 1'b1);
    apply("rd_40_again", 1'b1, 1'b0, 1'b1, 1'b0, 8'h40, 16'h0000, 16'h5A5A, 1'b1);

    // Reset on the same edge as a write must suppress the write.
    apply("wr_20",    1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 16'h1111, 16'h0000, 1'b1);
    apply("rst_wr_20",1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 16'hFFFF, 16'h0000, 1'b1);
`ifdef SRAM_MEM_CLEAR_EN
    exp_clr = 16'h0000;
    apply("rd_20_post", 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 16'h0000, exp_clr, 1'b1);
    apply("rd_12_post", 1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 16'h0000, exp_clr, 1'b1);
`else
    exp_clr = 16'h1111;
    apply("rd_20_post", 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 16'h0000, exp_clr, 1'b1);
    apply("rd_12_post", 1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 16'h0000, 16'hABCD, 1'b1);
`endif
    apply("rd_20_after_wr", 1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 16'h2222, 16'h0000, 1'b1);
    apply("raw_20",   1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 16'h0000, 16'h2222, 1'b1);

    // Idle: chip deselected while write strobe and bus toggle randomly.
    apply("wr_30",    1'b1, 1'b0, 1'b0, 1'b1, 8'h30, 16'h1234, 16'h0000, 1'b1);
    for (int k = 0; k < 10; k++) begin
      apply("idle", 1'b1, 1'b1, 1'($urandom_range(1, 0)), 1'b0,
            8'($urandom_range(255, 0)), 16'($urandom_range(65535, 0)), 16'h0000, 1'b1);
    end
    apply("rd_30",    1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 16'h0000, 16'h1234, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_256x16.md
Name: sram_256x16

Overview:
- Single-port synchronous static RAM, 256 words × 16 bits, with a shared bidirectional data bus.
- Sits beside the I2C slave front end. That block presents an 8-bit word address and 16-bit write data, and reads back 16-bit words that are returned to the master as two bytes.
- All control inputs are active-low, in the classic asynchronous-SRAM style. The block itself is fully synchronous to one clock.

Parameters:
- ADDR_WIDTH, 8, word-address width; depth = 2**ADDR_WIDTH (256).
- DATA_WIDTH, 16, word width and data bus width.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous reset, active-low; sampled on rising clk.
- address  input  ADDR_WIDTH  word address; sampled on rising clk.
- data  inout  DATA_WIDTH  shared bus; write data in, read data out; high-Z when not driving.
- chip_enable  input  1  active-low chip select; 1 = block idle.
- write_enable  input  1  active-low write strobe; 0 = write, 1 = read.
- output_enable  input  1  active-low output enable for the data bus.

Behaviour:
- Storage: array mem[0..255] of DATA_WIDTH bits, plus read register rd_q (DATA_WIDTH).
- Every valid address is used; there is no wrap-around and no out-of-range case.
- Priority per rising clk, highest first:
  - reset==0: rd_q <= 0. Memory is untouched (see Optional Feature). No write occurs, even if write strobes are active.
  - chip_enable==0 and write_enable==0 (WRITE): mem[address] <= data. rd_q is unchanged.
  - chip_enable==0 and write_enable==1 (READ): rd_q <= mem[address].
  - chip_enable==1: no state change.
- Read latency: 1 clock.
  - Address presented before edge N.
  - Data valid on the bus after edge N.
  - Data is held until the next READ edge or reset.
- Back-to-back reads at consecutive addresses yield one word per clock.
- Read-after-write to the same address on the next edge returns the new value.
- Bus drive: data = rd_q when chip_enable==0 && output_enable==0 && write_enable==1 && reset==1; otherwise data = Z. The drive decision is combinational on the control pins.
- No contention during writes: the block never drives while write_enable==0.
- Address or write data containing X/Z during WRITE: the location becomes X. A simulation warning is emitted; this is not masked.
- With output_enable==1 during READ, rd_q still updates but the bus stays Z.
- Reset mid-operation: a reset asserted on the same edge as a write suppresses the write. The bus releases to Z while reset==0.
- Power-up before the first reset: rd_q and memory are undefined (X).

Optional Feature:
- Macro: SRAM_MEM_CLEAR_EN.
- Defined: reset==0 on a rising clk also clears all 256 memory words to 0 in that single cycle. A read of any address after reset returns 16'h0000.
- Undefined: reset affects only rd_q. Memory contents persist across reset; locations never written read back X.

Test Plan:
- Reset: hold reset=0 for 2 clk with ce=0, oe=0, we=1 -> data is Z during reset. After release plus one READ edge at addr 0x00, rd_q shows 0x0000 with SRAM_MEM_CLEAR_EN, X without.
- Write/read: ce=0, we=0, addr=0x12, data=0xABCD for 1 clk; then we=1, oe=0, addr=0x12 -> data=0xABCD exactly one clk after the read edge.
- Burst: write 0x0001..0x0004 to addr 0xFE, 0xFF, 0x00, 0x01, then read in the same order on consecutive clocks -> 0x0001, 0x0002, 0x0003, 0x0004, one per clk, 1-cycle lag.
- Bus control: after reading 0x5A5A, set oe=1 -> data=Z. Set oe=0, ce=1 -> data=Z. Set we=0 -> data=Z and the bench-driven value is written, with no contention (no X on the bus).
- Reset priority: assert reset=0 on the same edge as ce=0, we=0, addr=0x20, data=0xFFFF -> a later read of 0x20 returns the prior contents (0x0000 with SRAM_MEM_CLEAR_EN).
- Idle: ce=1 with we=0 toggling and random address/data for 10 clk -> a previously written location 0x30=0x1234 still reads 0x1234.
